// File: rtl/ultrasonic_ranger.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ultrasonic_ranger
//
// Front end for a single HC-SR04-style ultrasonic sensor. While enabled, it
// runs a free-running measurement cycle: trigger pulse, wait for the echo,
// time the echo, then hold off until the period ends. Each measured echo width
// is compared against a range threshold. A required number of consecutive
// hits sets the debounced presence flag `detect`.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   enable       in   1 = run measurement cycles
//   echo         in   sensor echo pin (asynchronous, synchronized here)
//   trig         out  sensor trigger, registered
//   detect       out  debounced presence flag, registered
//   echo_cycles  out  last measured echo width in clk cycles (CNT_W bits)
//   meas_valid   out  one-cycle pulse when echo_cycles / timeout update
//   timeout      out  1 = last measurement had no echo or an over-long echo
//
// Optional build macro:
//   ULTRASONIC_CLEAR_HYST_EN - when defined, detect clears only after HITS
//   consecutive misses instead of on the first miss.
// ---------------------------------------------------------------------------
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES         = 500,
  parameter int ECHO_TIMEOUT_CYCLES = 1500000,
  parameter int PERIOD_CYCLES       = 3000000,
  parameter int THRESH_CYCLES       = 58000,
  parameter int HITS                = 3,
  parameter int CNT_W               = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic             detect,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             meas_valid,
  output logic             timeout
);

  // FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(ECHO_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(THRESH_CYCLES);
  localparam logic [3:0]       HITS_C    = 4'(HITS);

  // Echo synchronizer: meta -> s (synchronized) -> d (delayed, for edges)
  logic echo_meta_q, echo_s_q, echo_d_q;
  logic echo_rise, echo_fall;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;   // period counter, 0 at trig rise
  logic [CNT_W-1:0] tcnt_q, tcnt_d;   // trig width / echo-wait counter
  logic [CNT_W-1:0] wcnt_q, wcnt_d;   // echo width counter
  logic [3:0]       hcnt_q, hcnt_d;   // consecutive hit counter
`ifdef ULTRASONIC_CLEAR_HYST_EN
  logic [3:0]       mcnt_q, mcnt_d;   // consecutive miss counter
`endif

  logic             trig_q, trig_d;
  logic             detect_q, detect_d;
  logic [CNT_W-1:0] echo_cycles_q, echo_cycles_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;

  // Result-recording handshake between the FSM and the hit logic
  logic             rec;
  logic [CNT_W-1:0] rec_width;
  logic             rec_to;
  logic             rec_hit;

  assign echo_rise = echo_s_q & ~echo_d_q;
  assign echo_fall = ~echo_s_q & echo_d_q;

  always_comb begin
    state_d       = state_q;
    pcnt_d        = (pcnt_q == PER_LAST) ? pcnt_q : pcnt_q + CNT_ONE;
    tcnt_d        = tcnt_q;
    wcnt_d        = wcnt_q;
    hcnt_d        = hcnt_q;
`ifdef ULTRASONIC_CLEAR_HYST_EN
    mcnt_d        = mcnt_q;
`endif
    detect_d      = detect_q;
    echo_cycles_d = echo_cycles_q;
    timeout_d     = timeout_q;
    meas_valid_d  = 1'b0;
    rec           = 1'b0;
    rec_width     = echo_cycles_q;
    rec_to        = 1'b0;
    rec_hit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Period counter is frozen while idle
        pcnt_d = pcnt_q;
        if (enable) begin
          state_d = S_TRIG;
          pcnt_d  = '0;
          tcnt_d  = '0;
        end
      end

      S_TRIG: begin
        if (tcnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + CNT_ONE;
        end
      end

      S_WAIT: begin
        // Only a fresh rising edge counts; a level already high is ignored
        if (echo_rise) begin
          state_d = S_MEASURE;
          wcnt_d  = CNT_ONE;
        end else if (tcnt_q == TO_LAST) begin
          // No echo at all: width output keeps its previous value
          state_d   = S_HOLDOFF;
          rec       = 1'b1;
          rec_to    = 1'b1;
          rec_width = echo_cycles_q;
        end else begin
          tcnt_d = tcnt_q + CNT_ONE;
        end
      end

      S_MEASURE: begin
        if (echo_fall) begin
          state_d   = S_HOLDOFF;
          rec       = 1'b1;
          rec_width = wcnt_q;
        end else if (wcnt_q == TO_MAX) begin
          state_d   = S_HOLDOFF;
          rec       = 1'b1;
          rec_to    = 1'b1;
          rec_width = TO_MAX;
        end else begin
          wcnt_d = wcnt_q + CNT_ONE;
        end
      end

      S_HOLDOFF: begin
        if (pcnt_q == PER_LAST) begin
          if (enable) begin
            state_d = S_TRIG;
            pcnt_d  = '0;
            tcnt_d  = '0;
          end else begin
            state_d  = S_IDLE;
            hcnt_d   = '0;
            detect_d = 1'b0;
`ifdef ULTRASONIC_CLEAR_HYST_EN
            mcnt_d   = '0;
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result recording: outputs, valid pulse and debounce all move together
    if (rec) begin
      echo_cycles_d = rec_width;
      timeout_d     = rec_to;
      meas_valid_d  = 1'b1;
      rec_hit       = !rec_to && (rec_width < THRESH);
      if (rec_hit) begin
        hcnt_d   = (hcnt_q >= HITS_C) ? HITS_C : hcnt_q + 4'd1;
        detect_d = (hcnt_d == HITS_C);
`ifdef ULTRASONIC_CLEAR_HYST_EN
        mcnt_d   = '0;
`endif
      end else begin
`ifdef ULTRASONIC_CLEAR_HYST_EN
        mcnt_d = (mcnt_q >= HITS_C) ? HITS_C : mcnt_q + 4'd1;
        // While detecting, hcnt is held at HITS until enough misses arrive
        if (!detect_q || (mcnt_d == HITS_C)) begin
          hcnt_d   = '0;
          detect_d = 1'b0;
        end
`else
        hcnt_d   = '0;
        detect_d = 1'b0;
`endif
      end
    end

    // Trigger follows the next state so it is high exactly while in TRIG
    trig_d = (state_d == S_TRIG);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta_q   <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_d_q      <= 1'b0;
      state_q       <= S_IDLE;
      pcnt_q        <= '0;
      tcnt_q        <= '0;
      wcnt_q        <= '0;
      hcnt_q        <= '0;
`ifdef ULTRASONIC_CLEAR_HYST_EN
      mcnt_q        <= '0;
`endif
      trig_q        <= 1'b0;
      detect_q      <= 1'b0;
      echo_cycles_q <= '0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      echo_meta_q   <= echo;
      echo_s_q      <= echo_meta_q;
      echo_d_q      <= echo_s_q;
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      tcnt_q        <= tcnt_d;
      wcnt_q        <= wcnt_d;
      hcnt_q        <= hcnt_d;
`ifdef ULTRASONIC_CLEAR_HYST_EN
      mcnt_q        <= mcnt_d;
`endif
      trig_q        <= trig_d;
      detect_q      <= detect_d;
      echo_cycles_q <= echo_cycles_d;
      meas_valid_q  <= meas_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign trig        = trig_q;
  assign detect      = detect_q;
  assign echo_cycles = echo_cycles_q;
  assign meas_valid  = meas_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
`timescale 1ns/1ps
// Directed testbench for ultrasonic_ranger with small timing parameters.
module tb_ultrasonic_ranger;

  localparam int CW     = 12;
  localparam int TRIG   = 4;
  localparam int TO     = 100;
  localparam int PERIOD = 300;
  localparam int THR    = 50;
  localparam int NHITS  = 3;
  localparam int LIMIT  = 400;
`ifdef ULTRASONIC_CLEAR_HYST_EN
  localparam int HYST = 1;
`else
  localparam int HYST = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          echo;
  logic          trig;
  logic          detect;
  logic [CW-1:0] echo_cycles;
  logic          meas_valid;
  logic          timeout;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rise_cyc = 0;
  int have_rise = 0;
  int meas_idx = 0;

  ultrasonic_ranger #(
    .TRIG_CYCLES        (TRIG),
    .ECHO_TIMEOUT_CYCLES(TO),
    .PERIOD_CYCLES      (PERIOD),
    .THRESH_CYCLES      (THR),
    .HITS               (NHITS),
    .CNT_W              (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .detect     (detect),
    .echo_cycles(echo_cycles),
    .meas_valid (meas_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One measurement period: waits for trig, checks its width and spacing,
  // drives the echo pattern and checks the recorded result.
  task automatic do_meas(input int delay, input int width, input int pre_high,
                         input int drop_en, input int exp_ec, input int exp_to,
                         input int exp_det);
    int n;
    int tw;
    int got;
    int c_ec, c_to, c_det, mv_next;
    n = 0;
    while (trig !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("trig_rise_seen", int'(trig), 1);
    if (have_rise != 0) chk("trig_period", cyc - rise_cyc, PERIOD);
    rise_cyc  = cyc;
    have_rise = 1;
    if (pre_high != 0) echo = 1'b1;
    tw = 0;
    n  = 0;
    while (trig === 1'b1 && n < LIMIT) begin
      tw++;
      @(negedge clk);
      n++;
    end
    chk("trig_width", tw, TRIG);
    got = 0; c_ec = 0; c_to = 0; c_det = 0; mv_next = 0;
    fork
      begin
        if (pre_high != 0) begin
          repeat (150) @(negedge clk);
          echo = 1'b0;
        end else if (width > 0) begin
          repeat (delay) @(negedge clk);
          echo = 1'b1;
          repeat (width) @(negedge clk);
          echo = 1'b0;
        end
      end
      begin
        if (drop_en != 0) begin
          repeat (delay + 10) @(negedge clk);
          enable = 1'b0;
        end
      end
      begin
        n = 0;
        while (got == 0 && n < LIMIT) begin
          if (meas_valid === 1'b1) begin
            got   = 1;
            c_ec  = int'(echo_cycles);
            c_to  = int'(timeout);
            c_det = int'(detect);
            @(negedge clk);
            mv_next = int'(meas_valid);
          end else begin
            @(negedge clk);
            n++;
          end
        end
      end
    join
    meas_idx++;
    $display("meas %0d: width=%0d echo_cycles=%0d timeout=%0d detect=%0d",
             meas_idx, width, c_ec, c_to, c_det);
    chk("meas_valid_seen", got, 1);
    chk("meas_valid_pulse", mv_next, 0);
    chk("echo_cycles", c_ec, exp_ec);
    chk("timeout", c_to, exp_to);
    chk("detect", c_det, exp_det);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    echo   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", int'(trig), 0);
    chk("rst_detect", int'(detect), 0);
    chk("rst_echo_cycles", int'(echo_cycles), 0);
    chk("rst_meas_valid", int'(meas_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_trig", int'(trig), 0);

    enable = 1'b1;
    @(negedge clk);
    chk("trig_start", int'(trig), 1);

    //       delay width pre drop  ec   to  det
    do_meas(0,   0,   0, 0,   0,  1, 0);          // no echo
    do_meas(5,  30,   0, 0,  30,  0, 0);
    do_meas(5,  30,   0, 0,  30,  0, 0);
    do_meas(5,  30,   0, 0,  30,  0, 1);          // third hit
    do_meas(5,  70,   0, 0,  70,  0, HYST);
    do_meas(5,  70,   0, 0,  70,  0, HYST);
    do_meas(5,  70,   0, 0,  70,  0, 0);
    do_meas(5,  30,   0, 0,  30,  0, 0);
    do_meas(5,  30,   0, 0,  30,  0, 0);
    do_meas(5,  50,   0, 0,  50,  0, 0);          // equal to threshold: miss
    do_meas(5,  49,   0, 0,  49,  0, 0);
    do_meas(5,  30,   0, 0,  30,  0, 0);
    do_meas(5,  30,   0, 0,  30,  0, 1);          // 49 counted as a hit
    do_meas(5, 150,   0, 0, 100,  1, HYST);       // over-long echo
    do_meas(0,   0,   1, 0, 100,  1, HYST);       // echo high before wait
    do_meas(5,  30,   0, 0,  30,  0, HYST);
    do_meas(5,  30,   0, 0,  30,  0, HYST);
    do_meas(5,  30,   0, 1,  30,  0, 1);          // enable dropped mid-measure

    seen = 0;
    repeat (LIMIT) begin
      @(negedge clk);
      if (trig === 1'b1) seen = 1;
    end
    chk("no_trig_after_disable", seen, 0);
    chk("idle_detect", int'(detect), 0);
    chk("idle_echo_cycles_kept", int'(echo_cycles), 30);

    // Reset in the middle of a trigger pulse
    enable = 1'b1;
    n = 0;
    while (trig !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("trig_restart", int'(trig), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_trig", int'(trig), 0);
    chk("midrst_detect", int'(detect), 0);
    chk("midrst_echo_cycles", int'(echo_cycles), 0);
    chk("midrst_meas_valid", int'(meas_valid), 0);
    chk("midrst_timeout", int'(timeout), 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (trig === 1'b1) seen = 1;
    end
    chk("post_rst_no_trig", seen, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
